// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box scanner / outline drawer pair.
// Optional interior fill is enabled with the BBOX_FILL_EN macro.
package bbox_pkg;

  localparam int unsigned COORD_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    BOTTOM,
    LEFT,
    RIGHT,
`ifdef BBOX_FILL_EN
    FILL,
`endif
    FINISH
  } drawState_t;

  typedef struct packed {
    logic [COORD_W-1:0] xMin;
    logic [COORD_W-1:0] xMax;
    logic [COORD_W-1:0] yMin;
    logic [COORD_W-1:0] yMax;
  } box_t;

  // Number of outline pixels for a w x h box, each pixel counted once.
  function automatic int unsigned outline_count(int unsigned w, int unsigned h);
    if (h == 1) return w;
    if (w == 1) return h;
    return 2 * w + 2 * (h - 2);
  endfunction

endpackage

// File: rtl/bbox_outline_draw_if.sv
// Start handshake, box request and framebuffer write port of the outline drawer.
interface bbox_outline_draw_if #(
  parameter int unsigned ADDR_W = 14
);
  import bbox_pkg::*;

  logic               en;
  logic               rdy;
  logic [COORD_W-1:0] xMin;
  logic [COORD_W-1:0] xMax;
  logic [COORD_W-1:0] yMin;
  logic [COORD_W-1:0] yMax;
  logic [7:0]         colour;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         wrdata;
  logic               wren;
  logic               done;
  logic               err;

  modport master (
    output en, xMin, xMax, yMin, yMax, colour,
    input  rdy, addr, wrdata, wren, done, err
  );

  modport slave (
    input  en, xMin, xMax, yMin, yMax, colour,
    output rdy, addr, wrdata, wren, done, err
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Framebuffer address generator: load (x,y), then step by +1 (x) or +WIDTH (y).
module fb_addr_gen
  import bbox_pkg::*;
#(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned ADDR_W = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               stepX,
  input  logic               stepY,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0] addrQ;

  // Segment starts use a constant-coefficient product; per-pixel steps are adds only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrQ <= '0;
    end else if (load) begin
      addrQ <= ADDR_W'(ADDR_W'(y) * ADDR_W'(WIDTH)) + ADDR_W'(x);
    end else if (stepY) begin
      addrQ <= addrQ + ADDR_W'(WIDTH);
    end else if (stepX) begin
      addrQ <= addrQ + ADDR_W'(1);
    end
  end

  assign addr = addrQ;

endmodule

// File: rtl/bbox_outline_draw.sv
// Draws a bounding-box outline into a WIDTH x HEIGHT 8-bit framebuffer, one pixel per cycle.
// Define BBOX_FILL_EN to also paint the interior with FILL_COLOUR after the outline.
module bbox_outline_draw
  import bbox_pkg::*;
#(
  parameter int unsigned WIDTH  = 100,
  parameter int unsigned HEIGHT = 100,
  parameter int unsigned ADDR_W = 14
`ifdef BBOX_FILL_EN
  ,
  parameter logic [7:0]  FILL_COLOUR = 8'h00
`endif
) (
  input logic                clk,
  input logic                rst_n,
  bbox_outline_draw_if.slave bus
);

  drawState_t         state, stateN;
  box_t               box, boxN;
  logic [7:0]         col, colN;
  logic [COORD_W-1:0] x, y, xN, yN;
  logic               rdyQ, wrenQ, doneQ, errQ;
  logic               rdyN, wrenN, doneN, errN;
  logic [7:0]         wrdataQ, wrdataN;
  logic               agLoad, agStepX, agStepY;
  logic [ADDR_W-1:0]  agAddr;
  logic               boxValid_c;
  logic               hasSides_c;
  logic [COORD_W-1:0] yLast_c;
`ifdef BBOX_FILL_EN
  logic               hasInnerCols_c;
  logic [COORD_W-1:0] xLast_c;
`endif

  // Incoming box must be non-empty and inside the framebuffer.
  assign boxValid_c = (bus.xMin <= bus.xMax) && (bus.yMin <= bus.yMax) &&
                      (32'(bus.xMax) < WIDTH) && (32'(bus.yMax) < HEIGHT);

  // Side segments exist only when there is at least one row strictly between top and bottom.
  assign hasSides_c = box.yMax > (box.yMin + COORD_W'(1));
  assign yLast_c    = box.yMax - COORD_W'(1);
`ifdef BBOX_FILL_EN
  assign hasInnerCols_c = box.xMax > (box.xMin + COORD_W'(1));
  assign xLast_c        = box.xMax - COORD_W'(1);
`endif

  // Next-state, counter and address-generator control.
  always_comb begin
    stateN  = state;
    boxN    = box;
    colN    = col;
    xN      = x;
    yN      = y;
    errN    = errQ;
    agLoad  = 1'b0;
    agStepX = 1'b0;
    agStepY = 1'b0;
    rdyN    = 1'b0;
    wrenN   = 1'b0;
    doneN   = 1'b0;
    wrdataN = wrdataQ;

    unique case (state)
      IDLE: begin
        if (bus.en) begin
          boxN = '{xMin: bus.xMin, xMax: bus.xMax, yMin: bus.yMin, yMax: bus.yMax};
          colN = bus.colour;
          errN = !boxValid_c;
          if (boxValid_c) begin
            stateN = TOP;
            xN     = bus.xMin;
            yN     = bus.yMin;
            agLoad = 1'b1;
          end else begin
            stateN = FINISH;
          end
        end
      end
      TOP: begin
        if (x != box.xMax) begin
          xN      = x + COORD_W'(1);
          agStepX = 1'b1;
        end else if (box.yMax != box.yMin) begin
          stateN = BOTTOM;
          xN     = box.xMin;
          yN     = box.yMax;
          agLoad = 1'b1;
        end else begin
          stateN = FINISH;
        end
      end
      BOTTOM: begin
        if (x != box.xMax) begin
          xN      = x + COORD_W'(1);
          agStepX = 1'b1;
        end else if (hasSides_c) begin
          stateN = LEFT;
          xN     = box.xMin;
          yN     = box.yMin + COORD_W'(1);
          agLoad = 1'b1;
        end else begin
          stateN = FINISH;
        end
      end
      LEFT: begin
        if (y != yLast_c) begin
          yN      = y + COORD_W'(1);
          agStepY = 1'b1;
        end else if (box.xMax != box.xMin) begin
          stateN = RIGHT;
          xN     = box.xMax;
          yN     = box.yMin + COORD_W'(1);
          agLoad = 1'b1;
        end else begin
          stateN = FINISH;
        end
      end
      RIGHT: begin
        if (y != yLast_c) begin
          yN      = y + COORD_W'(1);
          agStepY = 1'b1;
`ifdef BBOX_FILL_EN
        end else if (hasInnerCols_c) begin
          stateN = FILL;
          xN     = box.xMin + COORD_W'(1);
          yN     = box.yMin + COORD_W'(1);
          agLoad = 1'b1;
`endif
        end else begin
          stateN = FINISH;
        end
      end
`ifdef BBOX_FILL_EN
      FILL: begin
        if (x != xLast_c) begin
          xN      = x + COORD_W'(1);
          agStepX = 1'b1;
        end else if (y != yLast_c) begin
          xN     = box.xMin + COORD_W'(1);
          yN     = y + COORD_W'(1);
          agLoad = 1'b1;
        end else begin
          stateN = FINISH;
        end
      end
`endif
      FINISH:  stateN = IDLE;
      default: stateN = IDLE;
    endcase

    rdyN    = (stateN == IDLE);
    doneN   = (stateN == FINISH);
    wrenN   = (stateN != IDLE) && (stateN != FINISH);
    wrdataN = colN;
`ifdef BBOX_FILL_EN
    if (stateN == FILL) wrdataN = FILL_COLOUR;
`endif
  end

  // State and output registers; outputs track the next state so they align with addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      box     <= '0;
      col     <= '0;
      x       <= '0;
      y       <= '0;
      rdyQ    <= 1'b1;
      wrenQ   <= 1'b0;
      doneQ   <= 1'b0;
      errQ    <= 1'b0;
      wrdataQ <= '0;
    end else begin
      state   <= stateN;
      box     <= boxN;
      col     <= colN;
      x       <= xN;
      y       <= yN;
      rdyQ    <= rdyN;
      wrenQ   <= wrenN;
      doneQ   <= doneN;
      errQ    <= errN;
      wrdataQ <= wrdataN;
    end
  end

  fb_addr_gen #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_addrGen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (agLoad),
    .stepX (agStepX),
    .stepY (agStepY),
    .x     (xN),
    .y     (yN),
    .addr  (agAddr)
  );

  assign bus.rdy    = rdyQ;
  assign bus.addr   = agAddr;
  assign bus.wrdata = wrdataQ;
  assign bus.wren   = wrenQ;
  assign bus.done   = doneQ;
  assign bus.err    = errQ;

endmodule

// File: tb/tb_bbox_outline_draw.sv
// Directed bench for bbox_outline_draw (WIDTH=HEIGHT=100); honours BBOX_FILL_EN.
module tb_bbox_outline_draw;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] expA[$];
  logic [7:0]  expD[$];
  logic [31:0] wrA[$];
  logic [31:0] wrD[$];
  int          wrC[$];

  bbox_outline_draw_if #(.ADDR_W(14)) bus ();

  bbox_outline_draw #(
    .WIDTH  (100),
    .HEIGHT (100),
    .ADDR_W (14)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with rdy=1; returns at the negedge after the accepting edge.
  task automatic startJob(input string tag, input int xa, input int xb,
                          input int ya, input int yb, input logic [7:0] c);
    chk({tag, " rdy before en"}, 32'(bus.rdy), 1);
    bus.xMin   = 11'(xa);
    bus.xMax   = 11'(xb);
    bus.yMin   = 11'(ya);
    bus.yMax   = 11'(yb);
    bus.colour = c;
    bus.en     = 1'b1;
    @(negedge clk);
    bus.en     = 1'b0;
  endtask

  // Collects writes until done, then compares against expA/expD.
  task automatic runJob(input string tag, input int budget);
    int  doneCyc;
    bit  gotDone;
    logic [31:0] obsA;
    logic [31:0] obsD;
    int  obsC;
    doneCyc = 0;
    gotDone = 1'b0;
    wrA.delete();
    wrD.delete();
    wrC.delete();
    for (int c = 1; c <= budget; c++) begin
      if (bus.wren === 1'b1) begin
        wrA.push_back(32'(bus.addr));
        wrD.push_back(32'(bus.wrdata));
        wrC.push_back(c);
      end
      if (bus.done === 1'b1) begin
        doneCyc = c;
        gotDone = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " done seen"}, 32'(gotDone), 1);
    chk({tag, " write count"}, 32'(wrA.size()), 32'(expA.size()));
    for (int i = 0; i < expA.size(); i++) begin
      obsA = (i < wrA.size()) ? wrA[i] : 32'hFFFF_FFFF;
      obsD = (i < wrD.size()) ? wrD[i] : 32'hFFFF_FFFF;
      obsC = (i < wrC.size()) ? wrC[i] : -1;
      chk($sformatf("%s addr[%0d]", tag, i), obsA, expA[i]);
      chk($sformatf("%s data[%0d]", tag, i), obsD, 32'(expD[i]));
      chk($sformatf("%s cycle[%0d]", tag, i), 32'(obsC), 32'(i + 1));
    end
    chk({tag, " done cycle"}, 32'(doneCyc), 32'(expA.size() + 1));
    chk({tag, " wren at done"}, 32'(bus.wren), 0);
    @(negedge clk);
    chk({tag, " rdy after done"}, 32'(bus.rdy), 1);
    chk({tag, " done one cycle"}, 32'(bus.done), 0);
  endtask

  task automatic exp3x3();
    expA = '{2010, 2011, 2012, 2210, 2211, 2212, 2110, 2112};
    expD = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef BBOX_FILL_EN
    expA.push_back(2111);
    expD.push_back(8'h00);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.xMin   = '0;
    bus.xMax   = '0;
    bus.yMin   = '0;
    bus.yMax   = '0;
    bus.colour = '0;

    // Reset held three cycles
    repeat (3) @(negedge clk);
    chk("reset rdy", 32'(bus.rdy), 1);
    chk("reset wren", 32'(bus.wren), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset err", 32'(bus.err), 0);
    chk("reset addr", 32'(bus.addr), 0);
    chk("reset wrdata", 32'(bus.wrdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single pixel at origin
    startJob("px0", 0, 0, 0, 0, 8'h5A);
    expA = '{0};
    expD = '{8'h5A};
    runJob("px0", 20);

    // 3x3 box; starts in the cycle rdy returns (back-to-back)
    startJob("box3", 10, 12, 20, 22, 8'hFF);
    exp3x3();
    runJob("box3", 30);

    // Full-width single row on the last line
    startJob("row", 0, 99, 99, 99, 8'h33);
    expA.delete();
    expD.delete();
    for (int i = 0; i < 100; i++) begin
      expA.push_back(32'(9900 + i));
      expD.push_back(8'h33);
    end
    runJob("row", 200);

    // Single column: top, bottom, then left side only
    startJob("col", 5, 5, 0, 3, 8'h11);
    expA = '{5, 305, 105, 205};
    expD = '{8'h11, 8'h11, 8'h11, 8'h11};
    runJob("col", 20);

    // 2x2 box: no side segments
    startJob("b2x2", 98, 99, 98, 99, 8'h22);
    expA = '{9898, 9899, 9998, 9999};
    expD = '{8'h22, 8'h22, 8'h22, 8'h22};
    runJob("b2x2", 20);

    // Invalid box (xMin > xMax): no writes, err set, done next cycle
    startJob("inv", 50, 40, 0, 0, 8'h44);
    chk("inv err", 32'(bus.err), 1);
    expA.delete();
    expD.delete();
    runJob("inv", 10);
    chk("inv err holds", 32'(bus.err), 1);

    // Valid job clears err at accept
    startJob("clr", 0, 0, 0, 0, 8'h66);
    chk("clr err cleared", 32'(bus.err), 0);
    expA = '{0};
    expD = '{8'h66};
    runJob("clr", 20);

    // yMax just outside the framebuffer
    startJob("ovf", 0, 0, 0, 100, 8'h77);
    chk("ovf err", 32'(bus.err), 1);
    chk("ovf wren", 32'(bus.wren), 0);
    chk("ovf done", 32'(bus.done), 1);
    @(negedge clk);
    chk("ovf rdy", 32'(bus.rdy), 1);

    // Reset after the third write of the 3x3 box
    startJob("rst", 10, 12, 20, 22, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    chk("rst third write wren", 32'(bus.wren), 1);
    chk("rst third write addr", 32'(bus.addr), 2012);
    rst_n = 1'b0;
    #1;
    chk("rst async wren", 32'(bus.wren), 0);
    chk("rst async rdy", 32'(bus.rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst rdy after release", 32'(bus.rdy), 1);
    chk("rst wren after release", 32'(bus.wren), 0);
    startJob("rerun", 10, 12, 20, 22, 8'hFF);
    exp3x3();
    runJob("rerun", 30);

`ifdef BBOX_FILL_EN
    // 4x4 box: outline then interior fill
    startJob("fill", 10, 13, 20, 23, 8'hAA);
    expA = '{2010, 2011, 2012, 2013, 2310, 2311, 2312, 2313,
             2110, 2210, 2113, 2213, 2111, 2112, 2211, 2212};
    expD = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
             8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
    runJob("fill", 40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
